dat_xfer_sequencer: RTL and testbench
=====================================

Name: dat_xfer_sequencer

Overview:
Control-side sequencer for the SD-host DAT datapath.
- Accepts one transfer request (direction, block count, block size, timeout) from the host register interface.
- Drives the DAT block's service controls (newService, writeRead, multiblock, blockSize, timeout, timeoutenable) block by block.
- Gates each block on FIFO readiness, runs a per-block watchdog, and reports completion or error back to the host.

Parameters:
NS_HOLD, 5, cycles dat_new_service stays high per block issue (covers the slower SDclock domain; must be >=2)
CNT_W, 16, width of block count and blocks_left

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  one-cycle request pulse; ignored unless busy=0
write  in  1  1 = host-to-SD write, 0 = SD-to-host read; sampled on start
block_count  in  CNT_W  number of blocks; 0 treated as 1
block_size  in  4  block size code passed through to DAT
timeout_value  in  16  per-block watchdog limit in clock cycles
timeout_en  in  1  enables watchdog and dat_timeoutenable
abort  in  1  level; forces termination
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
dat_block_done  in  1  one-cycle pulse from DAT at end of each block
dat_crc_error  in  1  one-cycle pulse from DAT on CRC/token failure
dat_new_service  out  1  service request to DAT
dat_write_read  out  1  direction to DAT
dat_multiblock  out  1  1 when latched block count > 1
dat_block_size  out  4  latched block_size
dat_timeout  out  16  latched timeout_value
dat_timeout_enable  out  1  latched timeout_en
busy  out  1  high from the cycle after accepted start until return to IDLE
done  out  1  one-cycle completion pulse
error  out  1  sticky until the next accepted start
error_code  out  2  00 none, 01 timeout, 10 crc, 11 abort
blocks_left  out  CNT_W  remaining blocks
stop_req  out  1  see Optional Feature

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, except dat_block_size=0 and dat_timeout=0.
- IDLE:
  - start=1 latches all request inputs and sets blocks_left = max(block_count,1).
  - Clears error/error_code; next state WAIT_FIFO.
  - start while busy is ignored.
- WAIT_FIFO:
  - Write: wait for fifo_empty=0. Read: wait for fifo_full=0.
  - When the condition holds, go to ISSUE.
- ISSUE:
  - dat_new_service=1 for exactly NS_HOLD cycles, then ACTIVE.
  - Watchdog counter cleared on ISSUE entry.
- ACTIVE:
  - Watchdog increments each cycle while timeout_en is latched.
  - counter == timeout_value: ERROR, code 01. timeout_value=0 with timeout_en: timeout fires on the 1st ACTIVE cycle.
  - dat_block_done: decrement blocks_left. If the new value is 0, go to FINISH; else go to WAIT_FIFO.
  - dat_crc_error: ERROR, code 10.
  - Same-cycle priority: crc_error > timeout > block_done.
- FINISH: done=1 for one cycle, then IDLE.
- ERROR: error=1, done=1 for one cycle, then IDLE. blocks_left holds its value at the time of the failure.
- abort=1 in any non-IDLE state: next cycle ERROR with code 11, dat_new_service dropped immediately. Abort has priority over all other events.
- dat_write_read, dat_multiblock, dat_block_size, dat_timeout, dat_timeout_enable hold their latched values from start until the next start.
- busy is low in IDLE and high in every other state.
- No wrap: blocks_left never decrements below 0. A dat_block_done outside ACTIVE is ignored.

Optional Feature:
- Macro SDH_AUTO_STOP_EN.
- Defined: a multiblock transfer (dat_multiblock=1) ending without error enters state STOP instead of FINISH.
  - STOP holds stop_req=1 until stop_ack (extra 1-bit input) is seen high, then goes to FINISH.
  - Watchdog also runs in STOP; expiry gives ERROR code 01.
  - abort in STOP gives code 11.
- Undefined: no stop_ack port, stop_req tied to 0, FINISH entered directly.

Test Plan:
- Write, block_count=1, fifo_empty=0 -> dat_new_service high 5 cycles, dat_multiblock=0; one dat_block_done -> done pulse, blocks_left=0, error=0.
- Read, block_count=3, fifo_full toggled high 10 cycles between blocks -> no issue while full; 3 service pulses total; done after the 3rd dat_block_done; dat_multiblock=1.
- timeout_en=1, timeout_value=20, no dat_block_done -> error=1, error_code=01 exactly 20 cycles after ACTIVE entry; blocks_left unchanged.
- dat_crc_error and dat_block_done in the same cycle on block 2 of 4 -> error_code=10, blocks_left=3.
- abort mid-ISSUE; then reset=0 pulse mid-ACTIVE -> abort: dat_new_service drops, error_code=11. Reset: all outputs 0 asynchronously; restart succeeds.
- SDH_AUTO_STOP_EN, 2 blocks -> stop_req held until stop_ack, then done; single block -> no stop_req.

Source files
------------

// File: rtl/dat_xfer_sequencer.sv
// Control-side sequencer for the SD-host DAT datapath: issues blocks, guards each one with a watchdog, reports done/error.
// Build option SDH_AUTO_STOP_EN adds a STOP handshake (stop_req/stop_ack) after a successful multiblock transfer.
module dat_xfer_sequencer #(
    parameter int NS_HOLD = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             write,
    input  logic [CNT_W-1:0] block_count,
    input  logic [3:0]       block_size,
    input  logic [15:0]      timeout_value,
    input  logic             timeout_en,
    input  logic             abort,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic             dat_block_done,
    input  logic             dat_crc_error,
`ifdef SDH_AUTO_STOP_EN
    input  logic             stop_ack,
`endif
    output logic             dat_new_service,
    output logic             dat_write_read,
    output logic             dat_multiblock,
    output logic [3:0]       dat_block_size,
    output logic [15:0]      dat_timeout,
    output logic             dat_timeout_enable,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       error_code,
    output logic [CNT_W-1:0] blocks_left,
    output logic             stop_req
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_FIFO = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_ACTIVE    = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;
`ifdef SDH_AUTO_STOP_EN
    localparam logic [2:0] S_STOP      = 3'd6;
`endif

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_TMO   = 2'b01;
    localparam logic [1:0] E_CRC   = 2'b10;
    localparam logic [1:0] E_ABORT = 2'b11;

    localparam int NS_W = $clog2(NS_HOLD);

    logic [2:0]       state_q,  state_d;
    logic [NS_W-1:0]  ns_cnt_q, ns_cnt_d;
    logic [15:0]      wd_q,     wd_d;
    logic [CNT_W-1:0] blocks_q, blocks_d;
    logic             wr_q,     wr_d;
    logic             mb_q,     mb_d;
    logic [3:0]       bs_q,     bs_d;
    logic [15:0]      tmo_q,    tmo_d;
    logic             tmo_en_q, tmo_en_d;
    logic             err_q,    err_d;
    logic [1:0]       code_q,   code_d;
    logic             wd_hit;

    assign wd_hit = tmo_en_q && (wd_q == tmo_q);

    always_comb begin
        state_d  = state_q;
        ns_cnt_d = ns_cnt_q;
        wd_d     = wd_q;
        blocks_d = blocks_q;
        wr_d     = wr_q;
        mb_d     = mb_q;
        bs_d     = bs_q;
        tmo_d    = tmo_q;
        tmo_en_d = tmo_en_q;
        err_d    = err_q;
        code_d   = code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WAIT_FIFO;
                    wr_d     = write;
                    mb_d     = (block_count > CNT_W'(1));
                    bs_d     = block_size;
                    tmo_d    = timeout_value;
                    tmo_en_d = timeout_en;
                    blocks_d = (block_count == '0) ? CNT_W'(1) : block_count;
                    err_d    = 1'b0;
                    code_d   = E_NONE;
                end
            end
            S_WAIT_FIFO: begin
                // Writes need data to send; reads need room to land data.
                if (wr_q ? !fifo_empty : !fifo_full) begin
                    state_d  = S_ISSUE;
                    ns_cnt_d = '0;
                    wd_d     = '0;
                end
            end
            S_ISSUE: begin
                wd_d = '0;
                if (ns_cnt_q == NS_W'(NS_HOLD - 1)) begin
                    state_d = S_ACTIVE;
                end else begin
                    ns_cnt_d = ns_cnt_q + NS_W'(1);
                end
            end
            S_ACTIVE: begin
                if (dat_crc_error) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    code_d  = E_CRC;
                end else if (wd_hit) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    code_d  = E_TMO;
                end else begin
                    if (tmo_en_q) begin
                        wd_d = wd_q + 16'd1;
                    end
                    if (dat_block_done) begin
                        if (blocks_q != '0) begin
                            blocks_d = blocks_q - CNT_W'(1);
                        end
                        if (blocks_q <= CNT_W'(1)) begin
`ifdef SDH_AUTO_STOP_EN
                            if (mb_q) begin
                                state_d = S_STOP;
                                wd_d    = '0;
                            end else begin
                                state_d = S_FINISH;
                            end
`else
                            state_d = S_FINISH;
`endif
                        end else begin
                            state_d = S_WAIT_FIFO;
                        end
                    end
                end
            end
`ifdef SDH_AUTO_STOP_EN
            S_STOP: begin
                if (wd_hit) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    code_d  = E_TMO;
                end else if (stop_ack) begin
                    state_d = S_FINISH;
                end else if (tmo_en_q) begin
                    wd_d = wd_q + 16'd1;
                end
            end
`endif
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort beats every other event; FINISH/ERROR are already terminating.
        if (abort && (state_q != S_IDLE) && (state_q != S_FINISH) && (state_q != S_ERROR)) begin
            state_d  = S_ERROR;
            err_d    = 1'b1;
            code_d   = E_ABORT;
            blocks_d = blocks_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ns_cnt_q <= '0;
            wd_q     <= '0;
            blocks_q <= '0;
            wr_q     <= 1'b0;
            mb_q     <= 1'b0;
            bs_q     <= '0;
            tmo_q    <= '0;
            tmo_en_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= E_NONE;
        end else begin
            state_q  <= state_d;
            ns_cnt_q <= ns_cnt_d;
            wd_q     <= wd_d;
            blocks_q <= blocks_d;
            wr_q     <= wr_d;
            mb_q     <= mb_d;
            bs_q     <= bs_d;
            tmo_q    <= tmo_d;
            tmo_en_q <= tmo_en_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign dat_new_service    = (state_q == S_ISSUE) && !abort;
    assign dat_write_read     = wr_q;
    assign dat_multiblock     = mb_q;
    assign dat_block_size     = bs_q;
    assign dat_timeout        = tmo_q;
    assign dat_timeout_enable = tmo_en_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_FINISH) || (state_q == S_ERROR);
    assign error              = err_q;
    assign error_code         = code_q;
    assign blocks_left        = blocks_q;
`ifdef SDH_AUTO_STOP_EN
    assign stop_req           = (state_q == S_STOP);
`else
    assign stop_req           = 1'b0;
`endif

endmodule

// File: tb/tb_dat_xfer_sequencer.sv
// Bench for dat_xfer_sequencer: directed scenarios plus randomized transfers, each judged
// by a per-transaction expectation built from block count, fault plan and watchdog limit.
module tb_dat_xfer_sequencer;
    localparam int NS_HOLD = 5;
    localparam int CNT_W   = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             write = 1'b0;
    logic [CNT_W-1:0] block_count = '0;
    logic [3:0]       block_size = '0;
    logic [15:0]      timeout_value = '0;
    logic             timeout_en = 1'b0;
    logic             abort = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_empty = 1'b0;
    logic             dat_block_done = 1'b0;
    logic             dat_crc_error = 1'b0;
`ifdef SDH_AUTO_STOP_EN
    logic             stop_ack = 1'b0;
`endif
    logic             dat_new_service;
    logic             dat_write_read;
    logic             dat_multiblock;
    logic [3:0]       dat_block_size;
    logic [15:0]      dat_timeout;
    logic             dat_timeout_enable;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       error_code;
    logic [CNT_W-1:0] blocks_left;
    logic             stop_req;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    dat_xfer_sequencer #(.NS_HOLD(NS_HOLD), .CNT_W(CNT_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .write              (write),
        .block_count        (block_count),
        .block_size         (block_size),
        .timeout_value      (timeout_value),
        .timeout_en         (timeout_en),
        .abort              (abort),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty),
        .dat_block_done     (dat_block_done),
        .dat_crc_error      (dat_crc_error),
`ifdef SDH_AUTO_STOP_EN
        .stop_ack           (stop_ack),
`endif
        .dat_new_service    (dat_new_service),
        .dat_write_read     (dat_write_read),
        .dat_multiblock     (dat_multiblock),
        .dat_block_size     (dat_block_size),
        .dat_timeout        (dat_timeout),
        .dat_timeout_enable (dat_timeout_enable),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .error_code         (error_code),
        .blocks_left        (blocks_left),
        .stop_req           (stop_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_service();
        for (int i = 0; i < 100 && !dat_new_service; i++) step();
        chk("service_seen", 32'(dat_new_service), 32'd1);
    endtask

    task automatic chk_all_zero();
        chk("rst_new_service", 32'(dat_new_service), 32'd0);
        chk("rst_write_read", 32'(dat_write_read), 32'd0);
        chk("rst_multiblock", 32'(dat_multiblock), 32'd0);
        chk("rst_block_size", 32'(dat_block_size), 32'd0);
        chk("rst_timeout", 32'(dat_timeout), 32'd0);
        chk("rst_timeout_en", 32'(dat_timeout_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_error_code", 32'(error_code), 32'd0);
        chk("rst_blocks_left", 32'(blocks_left), 32'd0);
        chk("rst_stop_req", 32'(stop_req), 32'd0);
    endtask

    // kind: 0 = clean transfer, 1 = crc error (with simultaneous block_done) on fail_blk,
    // 2 = watchdog expiry on fail_blk. hold = cycles the FIFO blocks between blocks.
    task automatic run_xfer(input bit wr, input int cnt, input int tmo, input bit ten,
                            input int kind, input int fail_blk, input int hold);
        int n;
        int left;
        int width;
        int d;
        int h;
        int dmax;
        logic [3:0] bs;
        n    = (cnt == 0) ? 1 : cnt;
        left = n;
        bs   = 4'($urandom_range(0, 15));
        dmax = ten ? ((tmo > 12) ? 11 : tmo - 1) : 11;
        write = wr; block_count = CNT_W'(cnt); block_size = bs;
        timeout_value = 16'(tmo); timeout_en = ten;
        fifo_full = 1'b0; fifo_empty = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("blocks_left_init", 32'(blocks_left), 32'(n));
        chk("error_cleared", 32'(error), 32'd0);
        chk("multiblock", 32'(dat_multiblock), 32'(n > 1));
        chk("write_read", 32'(dat_write_read), 32'(wr));
        chk("block_size", 32'(dat_block_size), 32'(bs));
        chk("timeout_val", 32'(dat_timeout), 32'(16'(tmo)));
        chk("timeout_en", 32'(dat_timeout_enable), 32'(ten));
        for (int b = 1; b <= n; b++) begin
            wait_service();
            width = 0;
            while (dat_new_service && width < 2 * NS_HOLD + 4) begin
                width++;
                step();
            end
            chk("ns_width", width, NS_HOLD);
            if ((kind == 2) && (b == fail_blk)) begin
                for (int i = 0; i < tmo; i++) step();
                chk("tmo_not_early", 32'(error), 32'd0);
                step();
                chk("tmo_error", 32'(error), 32'd1);
                chk("tmo_code", 32'(error_code), 32'd1);
                chk("tmo_done", 32'(done), 32'd1);
                chk("tmo_blocks_left", 32'(blocks_left), 32'(left));
                step();
                chk("tmo_idle", 32'(busy), 32'd0);
                chk("tmo_sticky", 32'(error), 32'd1);
                chk("tmo_done_once", 32'(done), 32'd0);
                return;
            end
            d = (dmax < 0) ? 0 : $urandom_range(0, dmax);
            for (int i = 0; i < d; i++) step();
            dat_block_done = 1'b1;
            dat_crc_error  = (kind == 1) && (b == fail_blk);
            step();
            dat_block_done = 1'b0;
            dat_crc_error  = 1'b0;
            if ((kind == 1) && (b == fail_blk)) begin
                chk("crc_error", 32'(error), 32'd1);
                chk("crc_code", 32'(error_code), 32'd2);
                chk("crc_done", 32'(done), 32'd1);
                chk("crc_blocks_left", 32'(blocks_left), 32'(left));
                step();
                chk("crc_idle", 32'(busy), 32'd0);
                return;
            end
            left--;
            chk("blocks_left", 32'(blocks_left), 32'(left));
            if (left == 0) begin
`ifdef SDH_AUTO_STOP_EN
                if (n > 1) begin
                    chk("stop_req_on", 32'(stop_req), 32'd1);
                    chk("stop_no_done", 32'(done), 32'd0);
                    h = $urandom_range(0, (dmax < 0) ? 0 : dmax);
                    for (int i = 0; i < h; i++) begin
                        step();
                        chk("stop_req_hold", 32'(stop_req), 32'd1);
                    end
                    stop_ack = 1'b1;
                    step();
                    stop_ack = 1'b0;
                end
`endif
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_no_error", 32'(error), 32'd0);
                chk("done_code", 32'(error_code), 32'd0);
                chk("done_no_stop_req", 32'(stop_req), 32'd0);
                chk("done_busy", 32'(busy), 32'd1);
                step();
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
            end else begin
                chk("mid_done_low", 32'(done), 32'd0);
                chk("mid_busy", 32'(busy), 32'd1);
                if (hold > 0) begin
                    if (wr) fifo_empty = 1'b1; else fifo_full = 1'b1;
                    for (int i = 0; i < hold; i++) begin
                        if (i == 1) begin start = 1'b1; write = ~wr; end
                        if (i == 2) begin start = 1'b0; write = wr; dat_block_done = 1'b1; end
                        if (i == 3) dat_block_done = 1'b0;
                        step();
                        chk("no_issue_blocked", 32'(dat_new_service), 32'd0);
                    end
                    start = 1'b0; write = wr; dat_block_done = 1'b0;
                    chk("start_ignored", 32'(dat_write_read), 32'(wr));
                    chk("stray_done_ignored", 32'(blocks_left), 32'(left));
                    fifo_empty = 1'b0; fifo_full = 1'b0;
                end
            end
        end
    endtask

    task automatic abort_in_issue();
        write = 1'b0; block_count = CNT_W'(2); block_size = 4'hA;
        timeout_value = 16'd0; timeout_en = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_service();
        step();
        step();
        chk("ns_before_abort", 32'(dat_new_service), 32'd1);
        abort = 1'b1;
        #1;
        chk("ns_drop_on_abort", 32'(dat_new_service), 32'd0);
        step();
        chk("abort_error", 32'(error), 32'd1);
        chk("abort_code", 32'(error_code), 32'd3);
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_blocks_left", 32'(blocks_left), 32'd2);
        abort = 1'b0;
        step();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_sticky", 32'(error), 32'd1);
    endtask

    task automatic reset_in_active();
        write = 1'b1; block_count = CNT_W'(3); block_size = 4'h5;
        timeout_value = 16'd100; timeout_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_service();
        for (int i = 0; i < NS_HOLD + 3 && dat_new_service; i++) step();
        step();
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero();
        step();
        reset = 1'b1;
        step();
        chk("post_reset_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int rwr;
        int rcnt;
        int rten;
        int rtmo;
        int rk;
        int rkind;
        int rfail;
        int rhold;
        int rn;
        reset = 1'b0;
        step();
        step();
        chk_all_zero();
        reset = 1'b1;
        step();

        run_xfer(1'b1, 1, 0, 1'b0, 0, 0, 0);
        run_xfer(1'b0, 3, 0, 1'b0, 0, 0, 10);
        run_xfer(1'b1, 2, 20, 1'b1, 2, 1, 0);
        run_xfer(1'b0, 4, 30, 1'b1, 1, 2, 0);
        run_xfer(1'b1, 3, 0, 1'b1, 2, 1, 0);
        run_xfer(1'b0, 0, 0, 1'b0, 0, 0, 0);
        abort_in_issue();
        reset_in_active();
        run_xfer(1'b1, 2, 15, 1'b1, 0, 0, 2);

        for (int t = 0; t < 30; t++) begin
            rwr   = $urandom_range(0, 1);
            rcnt  = $urandom_range(0, 5);
            rten  = $urandom_range(0, 1);
            rtmo  = $urandom_range(0, 30);
            rk    = $urandom_range(0, 4);
            rkind = (rk <= 2) ? 0 : ((rk == 3) ? 1 : 2);
            rn    = (rcnt == 0) ? 1 : rcnt;
            rfail = $urandom_range(1, rn);
            rhold = $urandom_range(0, 5);
            if (rkind == 2) rten = 1;
            if ((rten == 1) && (rtmo == 0)) begin
                rkind = 2;
                rfail = 1;
            end
            run_xfer(rwr[0], rcnt, rtmo, rten[0], rkind, rfail, rhold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
